// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory responder: accepts one request at a time and holds stall
// for a fixed latency, then pulses done with read data from an internal word array.
module mem_stall_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (LATENCY <= 2) ? 1 : $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   wr_q;
    logic                   unal_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [15:0]            wdata_q;
    logic [15:0]            data_out_q;
    logic                   done_q;
    logic                   err_q;
    logic [15:0]            mem_q [DEPTH];

    // Request seen on the edge that enters RESP: live inputs when LATENCY=1
    // jumps straight from IDLE, otherwise the copy latched at accept.
    logic                   rsp_wr_d;
    logic                   rsp_unal_d;
    logic [ADDR_BITS-1:0]   rsp_idx_d;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_BITS+1];

    always_comb begin
        rsp_wr_d   = wr_q;
        rsp_unal_d = unal_q;
        rsp_idx_d  = idx_q;
        if (state_q == IDLE) begin
            rsp_wr_d   = wr;
            rsp_unal_d = addr[0];
            rsp_idx_d  = addr[ADDR_BITS:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            unal_q     <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: the array is cleared on reset by design, so it lands in flops
            // rather than a RAM macro; a RAM-backed variant needs a clear sequencer.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        wr_q    <= wr;
                        unal_q  <= addr[0];
                        idx_q   <= addr[ADDR_BITS:1];
                        wdata_q <= data_in;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            err_q   <= rsp_unal_d;
                            if (rsp_unal_d)     data_out_q <= '0;
                            else if (!rsp_wr_d) data_out_q <= mem_q[rsp_idx_d];
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        err_q   <= rsp_unal_d;
                        if (rsp_unal_d)     data_out_q <= '0;
                        else if (!rsp_wr_d) data_out_q <= mem_q[rsp_idx_d];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (wr_q && !unal_q) mem_q[idx_q] <= wdata_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall    = ((state_q == IDLE) && enable) || (state_q == WAIT);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Scoreboard bench: one LATENCY=4 responder for the main scenarios and one
// LATENCY=1 responder for the held-enable case, sharing clock and reset.
module tb_mem_stall_responder;

    localparam int LAT_A = 4;
    localparam int AB    = 8;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, wr_a, stall_a, done_a, err_a, busy_a;
    logic [15:0] addr_a, din_a, dout_a;
    logic        en_b, wr_b, stall_b, done_b, err_b, busy_b;
    logic [15:0] addr_b, din_b, dout_b;

    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    resp_t       q_a[$];
    resp_t       q_b[$];
    logic [15:0] model[1 << AB];
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    mem_stall_responder #(.LATENCY(LAT_A), .ADDR_BITS(AB)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .wr(wr_a), .addr(addr_a), .data_in(din_a),
        .data_out(dout_a), .stall(stall_a), .done(done_a), .err(err_a), .busy(busy_a)
    );

    mem_stall_responder #(.LATENCY(1), .ADDR_BITS(AB)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .wr(wr_b), .addr(addr_b), .data_in(din_b),
        .data_out(dout_b), .stall(stall_b), .done(done_b), .err(err_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        foreach (model[i]) model[i] = '0;
        last_rd = '0;
        q_a.delete();
    endtask

    task automatic pop_a();
        resp_t e;
        if (q_a.size() == 0) begin
            check("a_unexpected_done", 1, 0);
            return;
        end
        e = q_a.pop_front();
        check("a_data", dout_a, e.data);
        check("a_err", err_a, e.err);
    endtask

    task automatic pop_b();
        resp_t e;
        if (q_b.size() == 0) begin
            check("b_unexpected_done", 1, 0);
            return;
        end
        e = q_b.pop_front();
        check("b_data", dout_b, e.data);
        check("b_err", err_b, e.err);
    endtask

    // Called at #1 after a rising edge; returns at the same phase one idle cycle after RESP.
    task automatic access_a(input logic w, input logic [15:0] a, input logic [15:0] d);
        resp_t          e;
        logic [AB-1:0]  idx;
        bit             got;
        got   = 1'b0;
        idx   = a[AB:1];
        e.err = a[0];
        if (a[0])   e.data = '0;
        else if (!w) e.data = model[idx];
        else        e.data = last_rd;
        q_a.push_back(e);
        en_a = 1'b1; wr_a = w; addr_a = a; din_a = d;
        for (int cyc = 0; cyc <= LAT_A + 2 && !got; cyc++) begin
            @(negedge clk);
            if (done_a) begin
                check("a_latency", cyc, LAT_A);
                check("a_stall_on_done", stall_a, 0);
                pop_a();
                got = 1'b1;
            end else begin
                check("a_stall_wait", stall_a, 1);
            end
            next_cycle();
        end
        if (!got) check("a_timeout", 0, 1);
        en_a = 1'b0; wr_a = 1'b0;
        last_rd = e.data;
        if (w && !a[0]) model[idx] = d;
        @(negedge clk);
        check("a_busy_after", busy_a, 0);
        check("a_done_after", done_a, 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_done[4];
        logic exp_stall[4];
        resp_t rb;
        exp_done  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_stall = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b0;
        en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
        en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
        clear_model();
        @(posedge clk);
        next_cycle();
        @(negedge clk);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_dout", dout_a, 16'h0000);
        check("rst_busy", busy_a, 0);
        check("rst_stall", stall_a, 0);
        check("rst_b_done", done_b, 0);
        next_cycle();
        rst = 1'b1;

        // Reset-then-read, unaligned write, and neighbour read (all zero after reset).
        access_a(1'b0, 16'h0010, 16'h0000);
        access_a(1'b1, 16'h0031, 16'hFFFF);
        access_a(1'b0, 16'h0030, 16'h0000);
        // Write/read-back, then aliasing across addr[15:9].
        access_a(1'b1, 16'h0020, 16'hBEEF);
        access_a(1'b0, 16'h0020, 16'h0000);
        access_a(1'b1, 16'h0004, 16'h1234);
        access_a(1'b0, 16'h0204, 16'h0000);

        // Reset in cycle 2 of an in-flight write.
        en_a = 1'b1; wr_a = 1'b1; addr_a = 16'h0040; din_a = 16'hAAAA;
        next_cycle();
        next_cycle();
        rst = 1'b0; en_a = 1'b0; wr_a = 1'b0;
        @(negedge clk);
        check("mid_busy_before", busy_a, 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", busy_a, 0);
        check("mid_done", done_a, 0);
        check("mid_stall", stall_a, 0);
        check("mid_dout", dout_a, 16'h0000);
        next_cycle();
        clear_model();
        access_a(1'b0, 16'h0040, 16'h0000);
        access_a(1'b0, 16'h0020, 16'h0000);

        // Short random aligned mix against the model.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra;
            ra = 16'($urandom) & 16'hFE1E;
            access_a(1'(($urandom_range(0, 1))), ra, 16'($urandom));
        end
        if (q_a.size() != 0) check("a_queue_empty", q_a.size(), 0);

        // LATENCY=1 with enable held for four cycles: accepts in cycles 0 and 2.
        rb.data = 16'h0000;
        rb.err  = 1'b0;
        q_b.push_back(rb);
        q_b.push_back(rb);
        en_b = 1'b1; wr_b = 1'b0; addr_b = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b_done_c%0d", i), done_b, exp_done[i]);
            check($sformatf("b_stall_c%0d", i), stall_b, exp_stall[i]);
            if (done_b) pop_b();
            next_cycle();
        end
        en_b = 1'b0;
        check("b_queue_empty", q_b.size(), 0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
